// File: rtl/i3c_timer_pkg.sv
// i3c_timer_pkg: shared types and timing constants for the I3C bus timer.
//   - timer_state_e : engine state (IDLE / POST_STOP / POST_START)
//   - entas_e       : ENTASx activity-state encodings
//   - timer_flags_t : sticky bus-condition flag bundle
//   - TNS_*         : timing requirements in nanoseconds
//   - ns_to_cycles  : ceiling conversion from ns to clock cycles
package i3c_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_POST_STOP  = 2'd1,
        ST_POST_START = 2'd2
    } timer_state_e;

    typedef enum logic [1:0] {
        ENTAS0 = 2'd0,
        ENTAS1 = 2'd1,
        ENTAS2 = 2'd2,
        ENTAS3 = 2'd3
    } entas_e;

    typedef struct packed {
        logic free_pure;
        logic crhpol;
        logic free_fm;
        logic aval;
        logic free_fm_p;
        logic idle;
        logic newcrlck_i2c;
        logic newcrlck_i3c;
    } timer_flags_t;

    localparam int unsigned TNS_CAS            = 39;
    localparam int unsigned TNS_CRHPOL         = 212;
    localparam int unsigned TNS_BUF_FM         = 500;
    localparam int unsigned TNS_AVAL           = 1000;
    localparam int unsigned TNS_BUF_FM_P       = 1300;
    localparam int unsigned TNS_NEWCRLOCK_I2C  = 300;
    localparam int unsigned TNS_NEWCRLOCK_I3C  = 1000;
    localparam int unsigned TNS_IDLE           = 200000;
    localparam int unsigned TNS_ENTAS0         = 1000;
    localparam int unsigned TNS_ENTAS1         = 100000;
    localparam int unsigned TNS_ENTAS2         = 2000000;
    localparam int unsigned TNS_ENTAS3         = 50000000;

    // Round up so a threshold is never shorter than the required time.
    function automatic int unsigned ns_to_cycles(input int unsigned ns, input int unsigned period);
        return (ns + period - 1) / period;
    endfunction

endpackage

// File: rtl/i3c_timer_satcnt.sv
// i3c_timer_satcnt: CNT_W-bit counter with clear, load-to-1 and saturating increment.
//   i_clk, i_rst_n : clock, async active-low reset
//   clr_i          : clear to 0 (highest priority)
//   load_i         : load 1 (pattern accepted)
//   inc_i          : increment, holding at all-ones
//   cnt_o          : registered count
module i3c_timer_satcnt #(
    parameter int unsigned CNT_W = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/i3c_bus_timer_gen2.sv
// i3c_bus_timer_gen2: I3C bus timing engine. Times the bus after START/STOP,
// raises sticky bus-condition flags and gates post-START clock release by ENTASx.
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_start_pattern           : START/Sr pulse (wins over STOP)
//   i_stop_pattern            : STOP pulse
//   i_crh_set, i_crh_entasx   : activity-state gating enable and ENTASx level
//   i_i3c_idle_flag           : bus released to open-drain idle
//   i_abort                   : synchronous return to IDLE, clears everything
//   o_timer_cas               : single-cycle clock-release pulse
//   o_timer_*                 : sticky bus-condition flags
//   o_busy                    : engine not in IDLE
// Optional macro I3C_TIMER_ELAPSED_OUT_EN adds o_elapsed (live count) and
// o_idle_latency (captured idle-flag rise count).
module i3c_bus_timer_gen2
    import i3c_timer_pkg::*;
#(
    parameter int unsigned CLK_PERIOD_NS = 20,
    parameter int unsigned CNT_W         = 24,
    parameter int unsigned T_CAS_NS      = TNS_CAS
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start_pattern,
    input  logic             i_stop_pattern,
    input  logic             i_crh_set,
    input  logic [1:0]       i_crh_entasx,
    input  logic             i_i3c_idle_flag,
    input  logic             i_abort,
    output logic             o_timer_cas,
    output logic             o_timer_bus_free_pure,
    output logic             o_timer_crhpol,
    output logic             o_timer_bus_free_mix_fm,
    output logic             o_timer_bus_aval,
    output logic             o_timer_bus_free_mix_fm_p,
    output logic             o_timer_bus_idle,
    output logic             o_timer_newcrlck_i2c,
    output logic             o_timer_newcrlck_i3c,
`ifdef I3C_TIMER_ELAPSED_OUT_EN
    output logic [CNT_W-1:0] o_elapsed,
    output logic [CNT_W-1:0] o_idle_latency,
`endif
    output logic             o_busy
);

    localparam int unsigned CYC_CAS      = ns_to_cycles(T_CAS_NS, CLK_PERIOD_NS);
    localparam int unsigned CYC_CRHPOL   = ns_to_cycles(TNS_CRHPOL, CLK_PERIOD_NS);
    localparam int unsigned CYC_BUF_FM   = ns_to_cycles(TNS_BUF_FM, CLK_PERIOD_NS);
    localparam int unsigned CYC_AVAL     = ns_to_cycles(TNS_AVAL, CLK_PERIOD_NS);
    localparam int unsigned CYC_BUF_FM_P = ns_to_cycles(TNS_BUF_FM_P, CLK_PERIOD_NS);
    localparam int unsigned CYC_LCK_I2C  = ns_to_cycles(TNS_NEWCRLOCK_I2C, CLK_PERIOD_NS);
    localparam int unsigned CYC_LCK_I3C  = ns_to_cycles(TNS_NEWCRLOCK_I3C, CLK_PERIOD_NS);
    localparam int unsigned CYC_IDLE     = ns_to_cycles(TNS_IDLE, CLK_PERIOD_NS);
    localparam int unsigned CYC_ENTAS0   = ns_to_cycles(TNS_ENTAS0, CLK_PERIOD_NS);
    localparam int unsigned CYC_ENTAS1   = ns_to_cycles(TNS_ENTAS1, CLK_PERIOD_NS);
    localparam int unsigned CYC_ENTAS2   = ns_to_cycles(TNS_ENTAS2, CLK_PERIOD_NS);
    localparam int unsigned CYC_ENTAS3   = ns_to_cycles(TNS_ENTAS3, CLK_PERIOD_NS);
    localparam longint unsigned CNT_MAX  = (64'd1 << CNT_W) - 64'd1;

    // Every threshold must be reachable by the saturating counter.
    if (64'(CYC_CAS) > CNT_MAX || 64'(CYC_CRHPOL) > CNT_MAX || 64'(CYC_BUF_FM) > CNT_MAX ||
        64'(CYC_AVAL) > CNT_MAX || 64'(CYC_BUF_FM_P) > CNT_MAX || 64'(CYC_LCK_I2C) > CNT_MAX ||
        64'(CYC_LCK_I3C) > CNT_MAX || 64'(CYC_IDLE) > CNT_MAX || 64'(CYC_ENTAS0) > CNT_MAX ||
        64'(CYC_ENTAS1) > CNT_MAX || 64'(CYC_ENTAS2) > CNT_MAX || 64'(CYC_ENTAS3) > CNT_MAX) begin : g_cnt_w_check
        $error("i3c_bus_timer_gen2: CNT_W too small for a derived threshold");
    end

    localparam logic [CNT_W-1:0] TH_CAS      = CNT_W'(CYC_CAS);
    localparam logic [CNT_W-1:0] TH_CRHPOL   = CNT_W'(CYC_CRHPOL);
    localparam logic [CNT_W-1:0] TH_BUF_FM   = CNT_W'(CYC_BUF_FM);
    localparam logic [CNT_W-1:0] TH_AVAL     = CNT_W'(CYC_AVAL);
    localparam logic [CNT_W-1:0] TH_BUF_FM_P = CNT_W'(CYC_BUF_FM_P);
    localparam logic [CNT_W-1:0] TH_LCK_I2C  = CNT_W'(CYC_LCK_I2C);
    localparam logic [CNT_W-1:0] TH_LCK_I3C  = CNT_W'(CYC_LCK_I3C);
    localparam logic [CNT_W-1:0] TH_IDLE     = CNT_W'(CYC_IDLE);

    function automatic logic [CNT_W-1:0] entas_cycles(input entas_e sel);
        case (sel)
            ENTAS0:  return CNT_W'(CYC_ENTAS0);
            ENTAS1:  return CNT_W'(CYC_ENTAS1);
            ENTAS2:  return CNT_W'(CYC_ENTAS2);
            default: return CNT_W'(CYC_ENTAS3);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    timer_state_e     state_q, state_d;
    timer_flags_t     flags_q, flags_d;
    logic             cas_q, cas_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] stp_idle_q, stp_idle_d;
    logic             stp_vld_q, stp_vld_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             idle_flag_q;

    logic             cnt_clr, cnt_load, cnt_inc;
    logic [CNT_W-1:0] cnt;
    logic             idle_rise;
    logic [CNT_W-1:0] lck_i2c_th, lck_i3c_th;

    i3c_timer_satcnt #(.CNT_W(CNT_W)) u_satcnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clr_i   (cnt_clr),
        .load_i  (cnt_load),
        .inc_i   (cnt_inc),
        .cnt_o   (cnt)
    );

    assign idle_rise  = i_i3c_idle_flag & ~idle_flag_q;
    assign lck_i2c_th = sat_add(stp_idle_q, TH_LCK_I2C);
    assign lck_i3c_th = sat_add(stp_idle_q, TH_LCK_I3C);

    // Next-state: abort > START > STOP > per-state timing.
    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        cas_d      = 1'b0;
        stp_idle_d = stp_idle_q;
        stp_vld_d  = stp_vld_q;
        target_d   = target_q;
        cnt_clr    = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;

        if (i_abort) begin
            state_d    = ST_IDLE;
            flags_d    = '0;
            stp_idle_d = '0;
            stp_vld_d  = 1'b0;
            target_d   = '0;
            cnt_clr    = 1'b1;
        end else if (i_start_pattern) begin
            state_d    = ST_POST_START;
            flags_d    = '0;
            stp_idle_d = '0;
            stp_vld_d  = 1'b0;
            target_d   = i_crh_set ? entas_cycles(entas_e'(i_crh_entasx)) : TH_CAS;
            cnt_load   = 1'b1;
        end else if (i_stop_pattern) begin
            // Flags from an earlier completed STOP stay sticky.
            state_d    = ST_POST_STOP;
            stp_idle_d = '0;
            stp_vld_d  = 1'b0;
            cnt_load   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_POST_STOP: begin
                    cnt_inc = 1'b1;
                    flags_d.free_pure = flags_q.free_pure | (cnt >= TH_CAS);
                    flags_d.crhpol    = flags_q.crhpol    | (cnt >= TH_CRHPOL);
                    flags_d.free_fm   = flags_q.free_fm   | (cnt >= TH_BUF_FM);
                    flags_d.aval      = flags_q.aval      | (cnt >= TH_AVAL);
                    flags_d.free_fm_p = flags_q.free_fm_p | (cnt >= TH_BUF_FM_P);
                    flags_d.newcrlck_i2c = flags_q.newcrlck_i2c | (stp_vld_q && (cnt >= lck_i2c_th));
                    flags_d.newcrlck_i3c = flags_q.newcrlck_i3c | (stp_vld_q && (cnt >= lck_i3c_th));
                    // Only the first rise after STOP defines the lock reference.
                    if (idle_rise && !stp_vld_q) begin
                        stp_idle_d = cnt;
                        stp_vld_d  = 1'b1;
                    end
                    if (cnt >= TH_IDLE) begin
                        flags_d.idle = 1'b1;
                        state_d      = ST_IDLE;
                        cnt_clr      = 1'b1;
                    end
                end
                ST_POST_START: begin
                    cnt_inc = 1'b1;
                    if (cnt == target_q) begin
                        cas_d   = 1'b1;
                        state_d = ST_IDLE;
                        cnt_clr = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            flags_q     <= '0;
            cas_q       <= 1'b0;
            busy_q      <= 1'b0;
            stp_idle_q  <= '0;
            stp_vld_q   <= 1'b0;
            target_q    <= '0;
            idle_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            cas_q       <= cas_d;
            busy_q      <= busy_d;
            stp_idle_q  <= stp_idle_d;
            stp_vld_q   <= stp_vld_d;
            target_q    <= target_d;
            idle_flag_q <= i_i3c_idle_flag;
        end
    end

    assign o_timer_cas               = cas_q;
    assign o_timer_bus_free_pure     = flags_q.free_pure;
    assign o_timer_crhpol            = flags_q.crhpol;
    assign o_timer_bus_free_mix_fm   = flags_q.free_fm;
    assign o_timer_bus_aval          = flags_q.aval;
    assign o_timer_bus_free_mix_fm_p = flags_q.free_fm_p;
    assign o_timer_bus_idle          = flags_q.idle;
    assign o_timer_newcrlck_i2c      = flags_q.newcrlck_i2c;
    assign o_timer_newcrlck_i3c      = flags_q.newcrlck_i3c;
    assign o_busy                    = busy_q;
`ifdef I3C_TIMER_ELAPSED_OUT_EN
    assign o_elapsed                 = cnt;
    assign o_idle_latency            = stp_idle_q;
`endif

endmodule

// File: tb/tb_i3c_bus_timer_gen2.sv
// tb_i3c_bus_timer_gen2: directed bench for i3c_bus_timer_gen2 with a
// time-since-pattern reference model and per-cycle output comparison.
module tb_i3c_bus_timer_gen2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_p, stop_p, crh_set, idle_flag, abort;
    logic [1:0]  entasx;
    logic        cas, free_pure, crhpol, fm, aval, fm_p, bidle, lck_i2c, lck_i3c, busy;
`ifdef I3C_TIMER_ELAPSED_OUT_EN
    logic [23:0] elapsed, idle_lat;
`endif
    logic [7:0]  dut_flags;

    int n_assert = 0;
    int n_fail   = 0;

    always #10 clk = ~clk;

    i3c_bus_timer_gen2 #(.CLK_PERIOD_NS(20), .CNT_W(24), .T_CAS_NS(39)) dut (
        .i_clk                     (clk),
        .i_rst_n                   (rst_n),
        .i_start_pattern           (start_p),
        .i_stop_pattern            (stop_p),
        .i_crh_set                 (crh_set),
        .i_crh_entasx              (entasx),
        .i_i3c_idle_flag           (idle_flag),
        .i_abort                   (abort),
        .o_timer_cas               (cas),
        .o_timer_bus_free_pure     (free_pure),
        .o_timer_crhpol            (crhpol),
        .o_timer_bus_free_mix_fm   (fm),
        .o_timer_bus_aval          (aval),
        .o_timer_bus_free_mix_fm_p (fm_p),
        .o_timer_bus_idle          (bidle),
        .o_timer_newcrlck_i2c      (lck_i2c),
        .o_timer_newcrlck_i3c      (lck_i3c),
`ifdef I3C_TIMER_ELAPSED_OUT_EN
        .o_elapsed                 (elapsed),
        .o_idle_latency            (idle_lat),
`endif
        .o_busy                    (busy)
    );

    assign dut_flags = {free_pure, crhpol, fm, aval, fm_p, bidle, lck_i2c, lck_i3c};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_assert++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: mode 0 = nothing pending, 1 = after STOP, 2 = after START.
    // k is the edge index that accepted the pattern; n = edges elapsed since then.
    int          cyc = 0, k = 0, target = 0, rise = -1, mode = 0;
    logic [7:0]  carried = '0;
    logic        prev_idle = 1'b0;
    logic [7:0]  f_pre;

    function automatic int entas_tbl(input logic [1:0] s);
        case (s)
            2'd0:    return 50;
            2'd1:    return 5000;
            2'd2:    return 100000;
            default: return 2500000;
        endcase
    endfunction

    function automatic logic [7:0] exp_flags();
        int n;
        logic [7:0] f;
        n = cyc - k;
        f = carried;
        if (mode == 1) begin
            f[7] = f[7] | (n >= 2);
            f[6] = f[6] | (n >= 11);
            f[5] = f[5] | (n >= 25);
            f[4] = f[4] | (n >= 50);
            f[3] = f[3] | (n >= 65);
            f[2] = f[2] | (n >= 10000);
            f[1] = f[1] | (rise >= 0 && rise + 15 <= 10000 && n >= rise + 15);
            f[0] = f[0] | (rise >= 0 && rise + 50 <= 10000 && n >= rise + 50);
        end
        return f;
    endfunction

    function automatic logic exp_busy();
        int n;
        n = cyc - k;
        if (mode == 1) return n < 10000;
        if (mode == 2) return n < target;
        return 1'b0;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mode = 0; carried = '0; rise = -1; prev_idle = 1'b0;
        end else begin
            f_pre = exp_flags();
            cyc++;
            if (abort) begin
                mode = 0; carried = '0; rise = -1;
            end else if (start_p) begin
                mode = 2; k = cyc; carried = '0; rise = -1;
                target = crh_set ? entas_tbl(entasx) : 2;
            end else if (stop_p) begin
                mode = 1; k = cyc; carried = f_pre; rise = -1;
            end else if (mode == 1 && rise < 0 && idle_flag && !prev_idle &&
                         (cyc - k) >= 1 && (cyc - k) <= 10000) begin
                rise = cyc - k;
            end
            prev_idle = idle_flag;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        check("flags", 32'(dut_flags), 32'(exp_flags()));
        check("busy", 32'(busy), 32'(exp_busy()));
        check("cas", 32'(cas), 32'(mode == 2 && (cyc - k) == target));
`ifdef I3C_TIMER_ELAPSED_OUT_EN
        check("elapsed", 32'(elapsed), exp_busy() ? 32'(cyc - k + 1) : 32'd0);
        check("idle_latency", 32'(idle_lat), (mode == 1 && rise >= 0) ? 32'(rise) : 32'd0);
`endif
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_stop();
        stop_p = 1'b1; adv(1); stop_p = 1'b0;
    endtask

    task automatic pulse_start();
        start_p = 1'b1; adv(1); start_p = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; start_p = 1'b0; stop_p = 1'b0; crh_set = 1'b0;
        entasx = 2'd0; idle_flag = 1'b0; abort = 1'b0;
        #2 rst_n = 1'b0;
        adv(3);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_flags", 32'(dut_flags), 32'd0);
        check("reset_cas", 32'(cas), 32'd0);
        rst_n = 1'b1;
        adv(2);

        // 1: async reset in the middle of a STOP sequence
        pulse_stop(); adv(30);
        check("t1_crhpol_before_rst", 32'(crhpol), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("t1_async_busy", 32'(busy), 32'd0);
        check("t1_async_flags", 32'(dut_flags), 32'd0);
        adv(2); rst_n = 1'b1; adv(100);
        check("t1_no_flags_after_rst", 32'(dut_flags), 32'd0);

        // 2: full STOP sequence with idle-flag rise sampled at count 5
        pulse_stop();
        adv(1);    check("t2_free_pure_1", 32'(free_pure), 32'd0);
        adv(1);    check("t2_free_pure_2", 32'(free_pure), 32'd1);
        adv(2);    idle_flag = 1'b1;
        adv(6);    check("t2_crhpol_10", 32'(crhpol), 32'd0);
        adv(1);    check("t2_crhpol_11", 32'(crhpol), 32'd1);
        adv(8);    check("t2_i2c_19", 32'(lck_i2c), 32'd0);
        adv(1);    check("t2_i2c_20", 32'(lck_i2c), 32'd1);
        adv(5);    check("t2_fm_25", 32'(fm), 32'd1);
        adv(24);   check("t2_aval_49", 32'(aval), 32'd0);
        adv(1);    check("t2_aval_50", 32'(aval), 32'd1);
        adv(4);    check("t2_i3c_54", 32'(lck_i3c), 32'd0);
        adv(1);    check("t2_i3c_55", 32'(lck_i3c), 32'd1);
        adv(10);   check("t2_fm_p_65", 32'(fm_p), 32'd1);
        adv(9934); check("t2_busy_9999", 32'(busy), 32'd1);
                   check("t2_idle_9999", 32'(bidle), 32'd0);
        adv(1);    check("t2_busy_10000", 32'(busy), 32'd0);
                   check("t2_idle_10000", 32'(bidle), 32'd1);
        idle_flag = 1'b0;
        adv(10);   check("t2_sticky", 32'(dut_flags), 32'hFF);

        // 3: START without gating clears flags, cas at 2
        pulse_start();
        check("t3_flags_cleared", 32'(dut_flags), 32'd0);
        check("t3_busy", 32'(busy), 32'd1);
        adv(1); check("t3_cas_1", 32'(cas), 32'd0);
        adv(1); check("t3_cas_2", 32'(cas), 32'd1);
        adv(1); check("t3_cas_3", 32'(cas), 32'd0);

        // 4: ENTAS1 held despite mid-wait change to 3
        crh_set = 1'b1; entasx = 2'd1;
        pulse_start();
        adv(100);  entasx = 2'd3;
        adv(4899); check("t4_cas_4999", 32'(cas), 32'd0);
        adv(1);    check("t4_cas_5000", 32'(cas), 32'd1);
        adv(1);    check("t4_cas_5001", 32'(cas), 32'd0);
        crh_set = 1'b0; entasx = 2'd0;

        // 5: Sr at count 40 of a STOP sequence
        pulse_stop(); adv(39);
        check("t5_fm_39", 32'(fm), 32'd1);
        pulse_start();
        check("t5_flags_cleared", 32'(dut_flags), 32'd0);
        adv(2);  check("t5_cas_2", 32'(cas), 32'd1);
        adv(60); check("t5_aval_never", 32'(aval), 32'd0);

        // 6: simultaneous START+STOP, then abort at count 3 of a STOP
        start_p = 1'b1; stop_p = 1'b1; adv(1); start_p = 1'b0; stop_p = 1'b0;
        adv(2); check("t6_start_wins_cas", 32'(cas), 32'd1);
        pulse_stop(); adv(2);
        check("t6_free_pure_2", 32'(free_pure), 32'd1);
        abort = 1'b1; adv(1); abort = 1'b0;
        check("t6_abort_busy", 32'(busy), 32'd0);
        check("t6_abort_flags", 32'(dut_flags), 32'd0);
        adv(20);

        // STOP during a gated START wait drops the pending cas
        crh_set = 1'b1; entasx = 2'd0;
        pulse_start(); adv(20); crh_set = 1'b0;
        pulse_stop(); adv(60);
        check("t7_aval_60", 32'(aval), 32'd1);
        abort = 1'b1; adv(1); abort = 1'b0; adv(5);

        // Idle flag already high at STOP: no rising edge, no lock
        idle_flag = 1'b1; adv(2);
        pulse_stop(); adv(100);
        check("t8_no_lock_i2c", 32'(lck_i2c), 32'd0);
        abort = 1'b1; adv(1); abort = 1'b0; idle_flag = 1'b0;
        adv(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
